// File: rtl/ex_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring, one quotient bit per cycle.
// Holds the front of the pipe while iterating and emits a one-cycle registered result.
module ex_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs1_rdata,
    input  logic [WIDTH-1:0] i_rs2_rdata,
    input  logic [4:0]       i_rd_waddr,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_res,
    output logic [4:0]       o_rd_waddr,
    output logic             o_rd_wen
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_d;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dvsr;
    logic [CW-1:0]    cnt;
    logic             is_rem, neg_q, neg_r;
    logic [4:0]       wa_q;

    logic             accept, special, a_neg, b_neg, ok;
    logic [WIDTH-1:0] abs_a, abs_b, spec_res, quo_n, res_fin, r_raw;
    logic [WIDTH+1:0] shifted, trial;
    logic [WIDTH:0]   rem_n;

    // Operand preparation and special-case detection for the accept cycle
    always_comb begin
        accept   = (state == IDLE) && i_vld && i_start && !i_flush;
        a_neg    = !i_op[0] && i_rs1_rdata[WIDTH-1];
        b_neg    = !i_op[0] && i_rs2_rdata[WIDTH-1];
        abs_a    = a_neg ? (~i_rs1_rdata + ONE) : i_rs1_rdata;
        abs_b    = b_neg ? (~i_rs2_rdata + ONE) : i_rs2_rdata;
        special  = (i_rs2_rdata == '0) ||
                   (!i_op[0] && (i_rs1_rdata == MIN_INT) && (i_rs2_rdata == '1));
        if (i_rs2_rdata == '0) spec_res = i_op[1] ? i_rs1_rdata : '1;
        else                   spec_res = i_op[1] ? '0 : MIN_INT;
    end

    // One restoring step; the extra top bit of the trial difference is the borrow
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {2'b00, dvsr};
        ok      = !trial[WIDTH+1];
        rem_n   = ok ? trial[WIDTH:0] : shifted[WIDTH:0];
        quo_n   = {quo[WIDTH-2:0], ok};
        r_raw   = rem_n[WIDTH-1:0];
        if (is_rem) res_fin = neg_r ? (~r_raw + ONE) : r_raw;
        else        res_fin = neg_q ? (~quo_n + ONE) : quo_n;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = special ? DONE : BUSY;
            BUSY:    if (i_flush) state_d = IDLE;
                     else if (cnt == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        o_stall  = accept || (state == BUSY);
        o_busy   = (state != IDLE);
        o_rd_wen = o_vld && (o_rd_waddr != 5'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vld      <= 1'b0;
            o_res      <= '0;
            o_rd_waddr <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            cnt        <= '0;
            is_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            wa_q       <= '0;
        end else begin
            o_vld <= (state_d == DONE);
            case (state)
                IDLE: if (accept) begin
                    if (special) begin
                        o_res      <= spec_res;
                        o_rd_waddr <= i_rd_waddr;
                    end else begin
                        rem    <= '0;
                        quo    <= abs_a;
                        dvsr   <= abs_b;
                        cnt    <= CW'(WIDTH-1);
                        is_rem <= i_op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        wa_q   <= i_rd_waddr;
                    end
                end
                BUSY: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - CNT_ONE;
                    // a flushed op must not disturb the held result
                    if (cnt == '0 && !i_flush) begin
                        o_res      <= res_fin;
                        o_rd_waddr <= wa_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: directed vector table, flush/reset sequences,
// and randomized ops checked against a plain-arithmetic RISC-V divide model.
module tb_ex_div_seq;
    logic        i_clk = 1'b0;
    logic        i_rst, i_vld, i_start, i_flush;
    logic [1:0]  i_op;
    logic [31:0] i_rs1_rdata, i_rs2_rdata;
    logic [4:0]  i_rd_waddr;
    logic        o_stall, o_busy, o_vld, o_rd_wen;
    logic [31:0] o_res;
    logic [4:0]  o_rd_waddr;

    int checks = 0;
    int errors = 0;

    ex_div_seq #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_start(i_start), .i_op(i_op),
        .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_rd_waddr(i_rd_waddr),
        .i_flush(i_flush), .o_stall(o_stall), .o_busy(o_busy), .o_vld(o_vld),
        .o_res(o_res), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics; SV signed / and % truncate toward zero
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Presents one op with i_start held high throughout (ignored outside IDLE).
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp, input int exp_lat);
        int lat, stalls;
        logic [31:0] res;
        @(negedge i_clk);
        i_vld = 1; i_start = 1; i_flush = 0;
        i_op = op; i_rs1_rdata = a; i_rs2_rdata = b; i_rd_waddr = wa;
        #1 chk({name, "_stall_accept"}, 32'(o_stall), 32'd1);
        lat = 0; stalls = 0;
        while (lat < 100) begin
            @(negedge i_clk);
            lat++;
            if (o_vld) break;
            if (o_stall) stalls++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
        chk({name, "_res"}, o_res, exp);
        chk({name, "_stall_done"}, 32'(o_stall), 32'd0);
        chk({name, "_waddr"}, 32'(o_rd_waddr), 32'(wa));
        chk({name, "_wen"}, 32'(o_rd_wen), 32'(wa != 0));
        res = o_res;
        i_vld = 0; i_start = 0;
        @(negedge i_clk);
        chk({name, "_vld_one"}, 32'(o_vld), 32'd0);
        chk({name, "_idle"}, 32'(o_busy), 32'd0);
        chk({name, "_hold"}, o_res, res);
    endtask

    vec_t tv[10];

    initial begin
        int vcount;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rwa;

        tv[0] = '{2'b01, 32'd100,        32'd7,          5'd1, 32'd14,         33};
        tv[1] = '{2'b11, 32'd100,        32'd7,          5'd2, 32'd2,          33};
        tv[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd3, 32'hFFFF_FFFD,  33};
        tv[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd4, 32'hFFFF_FFFF,  33};
        tv[4] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd5, 32'd1,          33};
        tv[5] = '{2'b01, 32'd5,          32'd0,          5'd6, 32'hFFFF_FFFF,  1};
        tv[6] = '{2'b11, 32'd5,          32'd0,          5'd7, 32'd5,          1};
        tv[7] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8, 32'h8000_0000,  1};
        tv[8] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9, 32'd0,          1};
        tv[9] = '{2'b00, 32'hFFFF_FFF9,  32'd0,          5'd10, 32'hFFFF_FFFF, 1};

        i_rst = 1; i_vld = 0; i_start = 0; i_flush = 0; i_op = 0;
        i_rs1_rdata = 0; i_rs2_rdata = 0; i_rd_waddr = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_res", o_res, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_wen", 32'(o_rd_wen), 32'd0);
        i_rst = 0;

        foreach (tv[i])
            run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].wa,
                   tv[i].exp, tv[i].lat);

        // Flush at T+10 kills the op; a fresh op right after completes normally
        @(negedge i_clk);
        i_vld = 1; i_start = 1; i_op = 2'b01; i_rs1_rdata = 100; i_rs2_rdata = 7; i_rd_waddr = 4;
        vcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (k == 1) begin i_vld = 0; i_start = 0; end
            vcount += int'(o_vld);
            if (k == 10) i_flush = 1;
        end
        @(negedge i_clk);
        chk("flush_busy", 32'(o_busy), 32'd0);
        chk("flush_vld", 32'(o_vld), 32'd0);
        chk("flush_no_vld_before", 32'(vcount), 32'd0);
        i_flush = 0;
        run_op("after_flush", 2'b01, 32'd9, 32'd3, 5'd11, 32'd3, 33);

        // Synchronous reset mid-operation discards the op and clears outputs
        @(negedge i_clk);
        i_vld = 1; i_start = 1; i_op = 2'b01; i_rs1_rdata = 100; i_rs2_rdata = 7; i_rd_waddr = 12;
        @(negedge i_clk);
        i_vld = 0; i_start = 0;
        repeat (4) @(negedge i_clk);
        i_rst = 1;
        @(negedge i_clk);
        chk("midrst_vld", 32'(o_vld), 32'd0);
        chk("midrst_res", o_res, 32'd0);
        chk("midrst_waddr", 32'(o_rd_waddr), 32'd0);
        chk("midrst_wen", 32'(o_rd_wen), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_stall", 32'(o_stall), 32'd0);
        i_rst = 0;
        vcount = 0;
        repeat (40) begin
            @(negedge i_clk);
            vcount += int'(o_vld);
        end
        chk("midrst_no_vld", 32'(vcount), 32'd0);
        run_op("x0_dest", 2'b01, 32'd50, 32'd5, 5'd0, 32'd10, 33);

        // Randomized ops against the arithmetic model, biased toward corner divisors
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom();
            case ($urandom_range(0, 5))
                0:       rb = 32'($urandom_range(0, 3));
                1:       rb = 32'hFFFF_FFFF;
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3:       rb = 32'($urandom_range(1, 1000));
                default: rb = $urandom();
            endcase
            rwa = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d", n), rop, ra, rb, rwa, ref_res(rop, ra, rb),
                   ref_lat(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
